// File: rtl/de2_hex_pkg.sv
// Shared types and constants for the DE2 HEX display arbiter.
// Active-low seven-segment table: bit 6 = g ... bit 0 = a, 0 lights a segment.
package de2_hex_pkg;

  localparam int SEG_W  = 7;
  localparam int DIGITS = 4;
  localparam int HOLD_W = 16;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/hex7seg_enc.sv
// Combinational hex nibble to active-low seven-segment encoder.
module hex7seg_enc
  import de2_hex_pkg::*;
(
  input  logic [3:0]       hex_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    seg_o = SEG_LUT[hex_i];
  end

endmodule

// File: rtl/de2_hex_display_arbiter.sv
// Round-robin arbiter sharing the DE2 HEX PIO between two requesters, with dwell.
// Optional readback check of the PIO contents is enabled by HEX_ARB_READBACK_EN.
module de2_hex_display_arbiter
  import de2_hex_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  output logic        busy,
  output logic        last_grant,
  output logic        err
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES == 0) ? '0 : HOLD_W'(HOLD_CYCLES - 1);
  localparam state_e AFTER_IO = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  last_grant_q, last_grant_d;
  logic [15:0]           data_q, data_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [SEG_W*DIGITS-1:0] seg_w;
  logic                  grant;
  logic                  unused_rd;

`ifdef HEX_ARB_READBACK_EN
  logic err_q, err_d;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    hex7seg_enc u_enc (
      .hex_i (data_q[4*g +: 4]),
      .seg_o (seg_w[SEG_W*g +: SEG_W])
    );
  end

  // Only both-valid contention consults the pointer; a lone requester always wins.
  assign grant = (req0_valid && req1_valid) ? ptr_q : req1_valid;

  // Handshake: a requester's value transfers on a clock edge where valid and ready
  // are both high; ready is only offered in IDLE and valid must not wait on ready.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    last_grant_d   = last_grant_q;
    data_d         = data_q;
    hold_d         = hold_q;
`ifdef HEX_ARB_READBACK_EN
    err_d          = err_q;
`endif
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if ((req0_valid || req1_valid) && reset_n) begin
          req0_ready   = !grant;
          req1_ready   = grant;
          data_d       = grant ? req1_data : req0_data;
          last_grant_d = grant;
          ptr_d        = !grant;
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_writedata  = {4'h0, seg_w};
`ifdef HEX_ARB_READBACK_EN
        state_d        = ST_READ;
`else
        state_d        = AFTER_IO;
        hold_d         = HOLD_LOAD;
`endif
      end
`ifdef HEX_ARB_READBACK_EN
      ST_READ: begin
        pio_chipselect = 1'b1;
        if (pio_readdata[SEG_W*DIGITS-1:0] != seg_w) err_d = 1'b1;
        state_d        = AFTER_IO;
        hold_d         = HOLD_LOAD;
      end
`endif
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_IDLE;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      last_grant_q <= 1'b0;
      data_q       <= 16'h0;
      hold_q       <= '0;
`ifdef HEX_ARB_READBACK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      hold_q       <= hold_d;
`ifdef HEX_ARB_READBACK_EN
      err_q        <= err_d;
`endif
    end
  end

`ifdef HEX_ARB_READBACK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign unused_rd   = ^pio_readdata;
  assign pio_address = 2'b00;
  assign busy        = (state_q != ST_IDLE);
  assign last_grant  = last_grant_q;

endmodule

// File: doc/de2_hex_display_arbiter.md
# de2_hex_display_arbiter

Shares the DE2 28-bit HEX display PIO between two requesters: a software mirror path and a hardware status source. Each requester offers a 16-bit hex value. The block arbitrates round-robin, encodes the value into four active-low seven-segment digits, and issues a single Avalon-MM write to the PIO s1 slave. It then holds the display for a programmable dwell time before granting again. It sits between the requesters and the PIO's slave port in the Nios II system.

## Interface
- HOLD_CYCLES, 1000, dwell cycles after each update before the next grant; legal range 0..65535
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a value; must not depend on req0_ready
- req0_data  in  16  requester 0 hex value, digit 0 = bits [3:0]
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid / req1_data / req1_ready  same widths and meaning, requester 1
- pio_address  out  2  PIO s1 address; always 0
- pio_chipselect  out  1  PIO chip select
- pio_write_n  out  1  PIO write strobe, active-low
- pio_writedata  out  32  {4'h0, seg[27:0]}
- pio_readdata  in  32  PIO readback; used only with HEX_ARB_READBACK_EN
- busy  out  1  state != IDLE
- last_grant  out  1  index of the most recently granted requester
- err  out  1  sticky readback mismatch; constant 0 without the macro

## Operation
- States: IDLE, WRITE, READ (macro only), HOLD.
- **IDLE**
  - If any valid is high, grant by round-robin. The pointer resets to requester 0. After a grant, the pointer favours the other requester.
  - The winner's ready is high combinationally in the same cycle. Data is latched, last_grant is updated, and the state goes to WRITE.
  - The loser's ready stays low; its request waits.
- **WRITE** (one cycle): pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata={4'h0, enc(d3), enc(d2), enc(d1), enc(d0)}. Next state is READ with the macro, otherwise HOLD.
- **READ** (one cycle): pio_chipselect=1, pio_write_n=1. The PIO returns readdata combinationally in this cycle, and it is sampled at the cycle's end. If pio_readdata[27:0] differs from the written segments, err is set. Next state is HOLD.
- **HOLD**: a counter is loaded with HOLD_CYCLES-1 on entry and decrements to 0, then the state goes to IDLE. With HOLD_CYCLES=0, HOLD is skipped and the next state is IDLE directly.
- Outside WRITE/READ: pio_chipselect=0, pio_write_n=1, pio_writedata=0.
- **Segment encoding**, bit 6=g … bit 0=a, 0 = lit:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, B→03, C→46, D→21, E→06, F→0E
- ready is never high outside IDLE. Valid arriving during WRITE/READ/HOLD waits and is not dropped.

## Timing
- Accept at edge N. Write on PIO bus during cycle N+1; PIO out_port updates at edge N+2.
- Earliest next accept: cycle N+2+HOLD_CYCLES without the macro, N+3+HOLD_CYCLES with it.
- Reset values: state IDLE, pointer 0, last_grant 0, err 0, pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0, both ready 0, busy 0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). A pending write is abandoned, and the PIO keeps its own state.
- err clears only on reset.

## Configuration
- HEX_ARB_READBACK_EN defined: READ state present, pio_readdata compared, err live.
- HEX_ARB_READBACK_EN undefined: no READ state, pio_readdata ignored, err tied 0, and latency is one cycle shorter.

## Structure
- Package de2_hex_pkg:
  - state enum
  - SEG_W=7, DIGITS=4
  - the 16-entry segment lookup constant
  - SEG_BLANK=7'h7F
- Sub-module hex7seg_enc: combinational 4-bit → 7-bit active-low encoder, instantiated four times.
- Arbiter pointer, FSM and hold counter live in the top module. The counter is 16 bits.

## Test plan
- **Reset:** assert reset_n=0 mid-HOLD → all outputs at reset values within the same cycle, err=0, and the next grant goes to req0.
- **Single request:** req0 value 0x0000, HOLD_CYCLES=4 → req0_ready pulses one cycle; one write with pio_writedata=32'h0810_2040; busy for 1+4 cycles (1+1+4 with the macro).
- **Encoding:** req1 0x8888 → writedata 32'h0000_0000; req1 0x1111 → writedata 32'h0F3E_7CF9.
- **Contention:** req0 and req1 valid together from reset → req0 granted first; req1 granted right after HOLD; then with both valid again → req0 granted (alternation).
- **Readback (macro):** PIO model returns correct data → err stays 0. Force pio_readdata=0 after writing 0x1111 → err=1 and stays 1 until reset.
- **Zero dwell:** HOLD_CYCLES=0 with req0 held valid → back-to-back writes every 2 cycles (3 with the macro), no skipped values.
